// File: rtl/seq_detect_pkg.sv
// Shared state encodings and default widths for the serial pattern detector controller.
package seq_detect_pkg;

  localparam int unsigned PAT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StArmed = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

endpackage

// File: rtl/seq_shift_match.sv
// Bit history, fill tracking and pattern comparator; hit is combinational on the current bit.
module seq_shift_match
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q;
  logic [PAT_W-1:0] hist_next;
  logic [FillW-1:0] fill_q;
  logic             full;

  assign hist_next = {hist_q[PAT_W-2:0], bit_in};
  // Full once the current bit completes a window of PAT_W samples.
  assign full      = (fill_q >= FillW'(PAT_W - 1));
  assign hit       = bit_valid && full && (hist_next == pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_valid) begin
      hist_q <= hist_next;
      if (hit && !overlap) begin
        fill_q <= '0;
      end else if (fill_q != FillW'(PAT_W)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector controller: FSM, match counter and LED indication.
// Optional LED stretch is built when SEQ_DETECT_CTRL_STRETCH_EN is defined.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned PAT_W       = PAT_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_cfg_valid,
  input  logic [PAT_W-1:0] i_cfg_pattern,
  input  logic             i_cfg_overlap,
  input  logic [CNT_W-1:0] i_cfg_max,
  output logic             o_cfg_ready,
  input  logic             i_arm,
  input  logic             i_disarm,
  input  logic             i_btn,
  input  logic             i_btn_valid,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_led,
  output logic [1:0]       o_state
);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic             ovl_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             idle_like, arm_go, cfg_load, shift_en, hit;

  assign idle_like = (state_q == StIdle) || (state_q == StDone);
  assign arm_go    = idle_like && i_arm && !i_disarm;
  assign cfg_load  = idle_like && i_cfg_valid && !i_disarm;
  assign shift_en  = (state_q == StArmed) && i_btn_valid && !i_disarm;

  seq_shift_match #(
    .PAT_W (PAT_W)
  ) u_shift_match (
    .clk       (i_clock),
    .rst       (i_reset),
    .bit_in    (i_btn),
    .bit_valid (shift_en),
    .clear     (i_disarm || arm_go),
    .overlap   (ovl_q),
    .pattern   (pat_q),
    .hit       (hit)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    match_d = 1'b0;
    if (i_disarm) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_go) begin
            state_d = StArmed;
            count_d = '0;
          end
        end
        StArmed: begin
          if (hit) begin
            match_d = 1'b1;
            count_d = count_q + 1'b1;
            if ((max_q != '0) && (count_d == max_q)) begin
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      count_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pat_q <= '0;
      ovl_q <= 1'b0;
      max_q <= '0;
    end else if (cfg_load) begin
      pat_q <= i_cfg_pattern;
      ovl_q <= i_cfg_overlap;
      max_q <= i_cfg_max;
    end
  end

`ifdef SEQ_DETECT_CTRL_STRETCH_EN
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  logic [HoldW-1:0] hold_q;

  // Every accepted match restarts the full stretch window.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      hold_q <= '0;
    end else if (match_d) begin
      hold_q <= HoldW'(HOLD_CYCLES);
    end else if (i_disarm) begin
      hold_q <= '0;
    end else if (hold_q != '0) begin
      hold_q <= hold_q - 1'b1;
    end
  end

  assign o_led = (hold_q != '0);
`else
  assign o_led = match_q && (HOLD_CYCLES != 0);
`endif

  assign o_cfg_ready   = (state_q == StIdle) || (state_q == StDone);
  assign o_match       = match_q;
  assign o_match_count = count_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed vector table, reset corner case and randomized model check.
module tb_seq_detect_ctrl;

  localparam int PW   = 4;
  localparam int CW   = 8;
  localparam int HOLD = 16;

  typedef struct packed {
    logic          cv;
    logic [PW-1:0] pat;
    logic          ovl;
    logic [CW-1:0] mx;
    logic          arm;
    logic          dis;
    logic          btn;
    logic          bv;
  } stim_t;

  typedef struct packed {
    stim_t         s;
    logic          em;
    logic [CW-1:0] ec;
    logic [1:0]    es;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_overlap, arm, disarm, btn, btn_valid;
  logic [PW-1:0] cfg_pattern;
  logic [CW-1:0] cfg_max;
  logic          cfg_ready, match, led;
  logic [CW-1:0] match_count;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_count, m_pat, m_ovl, m_max, m_hold;
  bit m_match, m_led;
  bit m_bits[$];

  seq_detect_ctrl #(
    .PAT_W       (PW),
    .CNT_W       (CW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_pattern (cfg_pattern),
    .i_cfg_overlap (cfg_overlap),
    .i_cfg_max     (cfg_max),
    .o_cfg_ready   (cfg_ready),
    .i_arm         (arm),
    .i_disarm      (disarm),
    .i_btn         (btn),
    .i_btn_valid   (btn_valid),
    .o_match       (match),
    .o_match_count (match_count),
    .o_led         (led),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_pat = 0; m_ovl = 0; m_max = 0; m_hold = 0;
    m_match = 0; m_led = 0;
    m_bits.delete();
  endtask

  // Matches are found by comparing the last PW accepted bits, read as a number, to the pattern.
  task automatic model_step(input stim_t s);
    m_match = 0;
    if (s.dis) begin
      m_state = 0;
      m_bits.delete();
    end else if (m_state == 0 || m_state == 2) begin
      if (s.cv) begin
        m_pat = int'(s.pat); m_ovl = int'(s.ovl); m_max = int'(s.mx);
      end
      if (s.arm) begin
        m_state = 1; m_count = 0;
        m_bits.delete();
      end
    end else if (m_state == 1 && s.bv) begin
      m_bits.push_back(s.btn);
      if (m_bits.size() > PW) void'(m_bits.pop_front());
      if (m_bits.size() == PW) begin
        int v;
        v = 0;
        for (int i = 0; i < PW; i++) v = v * 2 + int'(m_bits[i]);
        if (v == m_pat) begin
          m_match = 1;
          m_count = (m_count + 1) % (1 << CW);
          if (m_ovl == 0) m_bits.delete();
          if (m_max != 0 && m_count == m_max) m_state = 2;
        end
      end
    end
`ifdef SEQ_DETECT_CTRL_STRETCH_EN
    if (m_match) m_hold = HOLD;
    else if (s.dis) m_hold = 0;
    else if (m_hold > 0) m_hold--;
    m_led = (m_hold > 0);
`else
    m_led = m_match;
`endif
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".match"}, 32'(match), 32'(m_match));
    check({tag, ".count"}, 32'(match_count), 32'(m_count));
    check({tag, ".state"}, 32'(state), 32'(m_state));
    check({tag, ".ready"}, 32'(cfg_ready), 32'(m_state != 1));
    check({tag, ".led"}, 32'(led), 32'(m_led));
  endtask

  task automatic apply(input stim_t s, input string tag);
    cfg_valid = s.cv; cfg_pattern = s.pat; cfg_overlap = s.ovl; cfg_max = s.mx;
    arm = s.arm; disarm = s.dis; btn = s.btn; btn_valid = s.bv;
    model_step(s);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  function automatic vec_t mk(input logic cv, input logic [PW-1:0] pat, input logic ovl,
                              input logic [CW-1:0] mx, input logic a, input logic d,
                              input logic b, input logic bv, input logic em,
                              input logic [CW-1:0] ec, input logic [1:0] es);
    vec_t v;
    v.s = '{cv: cv, pat: pat, ovl: ovl, mx: mx, arm: a, dis: d, btn: b, bv: bv};
    v.em = em; v.ec = ec; v.es = es;
    return v;
  endfunction

  function automatic vec_t vb(input logic b, input logic em, input logic [CW-1:0] ec,
                              input logic [1:0] es);
    return mk(0, 4'h0, 0, 8'd0, 0, 0, b, 1, em, ec, es);
  endfunction

  function automatic stim_t idle_stim();
    return '{cv: 0, pat: 4'h0, ovl: 0, mx: 8'd0, arm: 0, dis: 0, btn: 0, bv: 0};
  endfunction

  vec_t tbl[$];
  stim_t s;

  initial begin
    cfg_valid = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_max = '0;
    arm = 0; disarm = 0; btn = 0; btn_valid = 0;
    rst = 1'b1;
    model_reset();
    #2;
    compare_model("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Overlap run
    tbl.push_back(mk(1, 4'b1010, 1, 8'd0, 1, 0, 0, 0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 1, 8'd1, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 0, 0, 8'd1, 2'd1));
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(0, 1, 8'd2, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd2, 2'd0));
    // Non-overlap run
    tbl.push_back(mk(1, 4'b1010, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 1, 8'd1, 2'd1));
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(0, 0, 8'd1, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 0, 0, 0, 8'd1, 2'd0));
    // Limit reached
    tbl.push_back(mk(1, 4'b1010, 1, 8'd2, 1, 0, 0, 0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 1, 8'd1, 2'd1));
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(0, 1, 8'd2, 2'd2));
    tbl.push_back(vb(1, 0, 8'd2, 2'd2));
    tbl.push_back(vb(0, 0, 8'd2, 2'd2));
    // Config ignored while armed, accepted in DONE
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 2'd1));
    tbl.push_back(mk(1, 4'b1100, 1, 8'd0, 0, 0, 1, 1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 1, 8'd1, 2'd1));
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(0, 1, 8'd2, 2'd2));
    tbl.push_back(mk(1, 4'b1100, 1, 8'd0, 0, 0, 0, 0, 0, 8'd2, 2'd2));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(1, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 0, 8'd0, 2'd1));
    tbl.push_back(vb(0, 1, 8'd1, 2'd1));
    // Disarm collides with the final matching bit
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(1, 0, 8'd1, 2'd1));
    tbl.push_back(vb(0, 0, 8'd1, 2'd1));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 0, 1, 0, 8'd1, 2'd0));
    tbl.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0, 0, 8'd1, 2'd0));

    foreach (tbl[i]) begin
      apply(tbl[i].s, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_match", i), 32'(match), 32'(tbl[i].em));
      check($sformatf("vec%0d.tbl_count", i), 32'(match_count), 32'(tbl[i].ec));
      check($sformatf("vec%0d.tbl_state", i), 32'(state), 32'(tbl[i].es));
    end

    // Asynchronous reset in the middle of a match indication
    s = idle_stim();
    s.arm = 1;
    apply(s, "rst_arm");
    for (int i = 0; i < 4; i++) begin
      s = idle_stim();
      s.bv = 1;
      s.btn = (i < 2);
      apply(s, "rst_bits");
    end
    check("rst_pre_match", 32'(match), 32'd1);
`ifdef SEQ_DETECT_CTRL_STRETCH_EN
    for (int i = 0; i < 4; i++) apply(idle_stim(), "stretch");
    check("rst_pre_led", 32'(led), 32'd1);
`endif
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_model("async_rst");
    check("async_rst_led", 32'(led), 32'd0);
    #3;
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      s.cv  = ($urandom % 8) == 0;
      s.pat = 4'($urandom);
      s.ovl = 1'($urandom);
      s.mx  = 8'($urandom % 4);
      s.arm = ($urandom % 10) == 0;
      s.dis = ($urandom % 40) == 0;
      s.btn = 1'($urandom);
      s.bv  = ($urandom % 4) != 0;
      apply(s, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
